fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: instruction word width.
REQ-002 SHALL have parameter NB_ADDR, default `ADDRWIDTH: PC and instruction-memory word-address width; memory depth 2^NB_ADDR words.
REQ-003 SHALL have parameter NB_PC_SRC, default 2: width of the next-PC select.
REQ-004 SHALL have ports: i_clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have ports: i_reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: i_enable  in  1  run/step enable from debug unit.
REQ-007 SHALL have ports: i_pc_write  in  1  PC update permit from hazard logic, 0 = stall.
REQ-008 SHALL have ports: i_IF_ID_write  in  1  IF/ID latch update permit, 0 = hold.
REQ-009 SHALL have ports: i_branch_or_jump  in  1  taken branch/jump resolved in decode.
REQ-010 SHALL have ports: i_pc_src  in  NB_PC_SRC  target select: 01 branch, 10 jump, 11 register, 00 sequential.
REQ-011 SHALL have ports: i_addr_branch, i_addr_jump, i_addr_register  in  NB_ADDR each  candidate targets.
REQ-012 SHALL have ports: i_halt  in  1  HALT decoded.
REQ-013 SHALL have ports: i_load_valid  in  1, i_load_data  in  NB_DATA  debug program-load write.
REQ-014 SHALL have ports: o_instruction  out  NB_DATA  IF/ID instruction; o_pc  out  NB_ADDR  IF/ID PC+1.
REQ-015 SHALL have ports: o_load_full  out  1  memory full; o_halted  out  1  fetch frozen; o_fetch_pc  out  NB_ADDR  current PC.

Function
REQ-016 SHALL read instruction memory combinationally at address PC.
REQ-017 SHALL compute next PC: i_branch_or_jump=0 -> PC+1; else 01 -> i_addr_branch, 10 -> i_addr_jump, 11 -> i_addr_register, 00 -> PC+1.
REQ-018 SHALL wrap PC+1 modulo 2^NB_ADDR; o_pc likewise.
REQ-019 SHALL update PC only when i_enable=1, i_pc_write=1, halted=0.
REQ-020 SHALL update IF/ID only when i_enable=1 and i_IF_ID_write=1; otherwise hold both outputs.
REQ-021 SHALL, on an IF/ID update with i_branch_or_jump=1, load o_instruction=0 (NOP) and o_pc=PC+1 (one-slot flush).
REQ-022 SHALL, on an IF/ID update with no flush and halted=0, load o_instruction=mem[PC], o_pc=PC+1.
REQ-023 SHALL set halted on the edge where i_enable=1 and i_halt=1; halted clears only by reset.
REQ-024 SHALL, while halted, freeze PC and load NOP into IF/ID on each enabled update.
REQ-025 SHALL, when i_pc_write=0 and i_branch_or_jump=1 simultaneously, hold PC (stall wins); flush still applies if IF/ID updates.
REQ-026 SHALL accept program load only when i_enable=0 and o_load_full=0: write i_load_data at load pointer, increment pointer.
REQ-027 SHALL assert o_load_full when the load pointer has written word 2^NB_ADDR-1; further i_load_valid ignored, pointer saturates (no wrap).
REQ-028 SHALL ignore i_load_valid while i_enable=1.
REQ-029 SHALL have state machine LOAD (i_enable=0), RUN (i_enable=1, not halted), HALTED; LOAD->RUN on i_enable=1; RUN->LOAD on i_enable=0 (pause, state retained); RUN->HALTED per REQ-023; HALTED exits only via reset.

Reset
REQ-030 SHALL, on i_reset=0 asynchronously, clear PC, load pointer, o_instruction, o_pc, o_load_full, o_halted to 0 and enter LOAD.
REQ-031 SHALL NOT clear instruction-memory contents on reset.
REQ-032 SHALL, on reset asserted mid-load or mid-run, abandon the operation immediately; release resumes from PC=0, pointer=0.

Structure
REQ-033 SHALL take NB_ADDR, NOP encoding and PC_SRC codes (PC_SRC_SEQ/BRANCH/JUMP/REG) from the shared parameters.vh.
REQ-034 SHALL place the memory in one sub-module, instruction_memory (sync write, async read).

Verification
REQ-035 SHALL test: load 4 words 0x11,0x22,0x33,0x44, enable -> o_instruction 0x11,0x22,0x33,0x44 on cycles 1-4, o_pc 1..4.
REQ-036 SHALL test: at PC=2, i_branch_or_jump=1, i_pc_src=01, i_addr_branch=9 -> next o_instruction=0, following = mem[9], o_pc=10.
REQ-037 SHALL test: i_pc_write=0, i_IF_ID_write=0 for 2 cycles at PC=3 -> PC and IF/ID outputs unchanged, then resume with mem[3].
REQ-038 SHALL test: i_halt=1 at PC=5 -> o_halted=1 next edge, PC stays 5, o_instruction=0 thereafter despite i_enable=1.
REQ-039 SHALL test: load 2^NB_ADDR+3 words -> o_load_full=1 after word 2^NB_ADDR, extra writes leave mem[0] intact.
REQ-040 SHALL test: assert i_reset=0 between clock edges mid-run -> all outputs 0 immediately; after release, fetch restarts at mem[0].

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage: address width,
// NOP encoding, next-PC select codes and the fetch control states.
package fetch_pkg;

    localparam int          ADDRWIDTH = 8;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_instruction_memory.sv
// Instruction memory: synchronous write port for program load,
// asynchronous read port for fetch.
module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               i_clock,
    input  logic               i_write_enable,
    input  logic [NB_ADDR-1:0] i_write_addr,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [NB_ADDR-1:0] i_read_addr,
    output logic [NB_DATA-1:0] o_read_data
);

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    // NOTE: the array has no reset so it maps onto RAM and the loaded program survives a reset.
    always_ff @(posedge i_clock) begin
        if (i_write_enable) begin
            mem[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = mem[i_read_addr];

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID latch with
// one-slot flush, HALT freeze, and the debug program-load path.
module fetch
    import fetch_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_ADDR   = ADDRWIDTH,
    parameter int NB_PC_SRC = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_pc_write,
    input  logic                 i_IF_ID_write,
    input  logic                 i_branch_or_jump,
    input  logic [NB_PC_SRC-1:0] i_pc_src,
    input  logic [NB_ADDR-1:0]   i_addr_branch,
    input  logic [NB_ADDR-1:0]   i_addr_jump,
    input  logic [NB_ADDR-1:0]   i_addr_register,
    input  logic                 i_halt,
    input  logic                 i_load_valid,
    input  logic [NB_DATA-1:0]   i_load_data,
    output logic [NB_DATA-1:0]   o_instruction,
    output logic [NB_ADDR-1:0]   o_pc,
    output logic                 o_load_full,
    output logic                 o_halted,
    output logic [NB_ADDR-1:0]   o_fetch_pc
);

    fetch_state_e       state;
    logic [NB_ADDR-1:0] pc;
    logic [NB_ADDR-1:0] pc_plus_one;
    logic [NB_ADDR-1:0] pc_next;
    logic [NB_ADDR-1:0] load_ptr;
    logic [NB_DATA-1:0] mem_data;
    logic               halted;
    logic               pc_update;
    logic               ifid_update;
    logic               load_write;

    assign halted      = (state == S_HALTED);
    assign pc_plus_one = pc + NB_ADDR'(1);
    // The halting edge itself must not advance the PC, so i_halt gates it too.
    assign pc_update   = i_enable && i_pc_write && !halted && !i_halt;
    assign ifid_update = i_enable && i_IF_ID_write;
    assign load_write  = i_load_valid && !i_enable && !o_load_full;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pc_next = pc_plus_one;
        if (i_branch_or_jump) begin
            case (i_pc_src)
                NB_PC_SRC'(PC_SRC_BRANCH): pc_next = i_addr_branch;
                NB_PC_SRC'(PC_SRC_JUMP):   pc_next = i_addr_jump;
                NB_PC_SRC'(PC_SRC_REG):    pc_next = i_addr_register;
                default:                   pc_next = pc_plus_one;
            endcase
        end
    end

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .i_clock        (i_clock),
        .i_write_enable (load_write),
        .i_write_addr   (load_ptr),
        .i_write_data   (i_load_data),
        .i_read_addr    (pc),
        .o_read_data    (mem_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_LOAD;
        end else begin
            case (state)
                S_LOAD, S_RUN: begin
                    if (i_enable && i_halt) state <= S_HALTED;
                    else if (i_enable)      state <= S_RUN;
                    else                    state <= S_LOAD;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_LOAD;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pc <= '0;
        end else if (pc_update) begin
            pc <= pc_next;
        end
    end

    // A taken branch/jump or a halted core squashes the slot behind it with a NOP.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_instruction <= '0;
            o_pc          <= '0;
        end else if (ifid_update) begin
            o_pc <= pc_plus_one;
            if (i_branch_or_jump || halted) o_instruction <= NB_DATA'(NOP);
            else                            o_instruction <= mem_data;
        end
    end

    // The pointer saturates on the last word; the full flag then blocks further writes.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            load_ptr    <= '0;
            o_load_full <= 1'b0;
        end else if (load_write) begin
            if (load_ptr == {NB_ADDR{1'b1}}) o_load_full <= 1'b1;
            else                             load_ptr    <= load_ptr + NB_ADDR'(1);
        end
    end

    assign o_halted   = halted;
    assign o_fetch_pc = pc;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: program load, sequential fetch, branch/jump
// flush, stall, pause, PC wrap, HALT freeze and asynchronous reset.
module tb_fetch;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 4;
    localparam int DEPTH   = 2**NB_ADDR;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_enable;
    logic               i_pc_write;
    logic               i_IF_ID_write;
    logic               i_branch_or_jump;
    logic [1:0]         i_pc_src;
    logic [NB_ADDR-1:0] i_addr_branch;
    logic [NB_ADDR-1:0] i_addr_jump;
    logic [NB_ADDR-1:0] i_addr_register;
    logic               i_halt;
    logic               i_load_valid;
    logic [NB_DATA-1:0] i_load_data;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_ADDR-1:0] o_pc;
    logic               o_load_full;
    logic               o_halted;
    logic [NB_ADDR-1:0] o_fetch_pc;

    fetch #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .NB_PC_SRC (2)
    ) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_pc_write       (i_pc_write),
        .i_IF_ID_write    (i_IF_ID_write),
        .i_branch_or_jump (i_branch_or_jump),
        .i_pc_src         (i_pc_src),
        .i_addr_branch    (i_addr_branch),
        .i_addr_jump      (i_addr_jump),
        .i_addr_register  (i_addr_register),
        .i_halt           (i_halt),
        .i_load_valid     (i_load_valid),
        .i_load_data      (i_load_data),
        .o_instruction    (o_instruction),
        .o_pc             (o_pc),
        .o_load_full      (o_load_full),
        .o_halted         (o_halted),
        .o_fetch_pc       (o_fetch_pc)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic               en, pcw, ifw, boj;
        logic [1:0]         src;
        logic [NB_ADDR-1:0] ab, aj, ar;
        logic               halt;
        logic [NB_DATA-1:0] e_instr;
        logic [NB_ADDR-1:0] e_pc, e_fpc;
        logic               e_halted;
    } vec_t;

    typedef struct {
        logic [NB_DATA-1:0] instr;
        logic [NB_ADDR-1:0] pc, fpc;
        logic               halted;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t seg_a[$];
    vec_t seg_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, pcw, ifw, boj, input logic [1:0] src,
                                input int ab, aj, ar, input logic halt,
                                input logic [31:0] ei, input int ep, ef, input logic eh);
        vec_t v;
        v.en = en; v.pcw = pcw; v.ifw = ifw; v.boj = boj; v.src = src;
        v.ab = NB_ADDR'(ab); v.aj = NB_ADDR'(aj); v.ar = NB_ADDR'(ar); v.halt = halt;
        v.e_instr = ei; v.e_pc = NB_ADDR'(ep); v.e_fpc = NB_ADDR'(ef); v.e_halted = eh;
        return v;
    endfunction

    task automatic idle_inputs();
        i_enable = 0; i_pc_write = 1; i_IF_ID_write = 1; i_branch_or_jump = 0;
        i_pc_src = 2'b00; i_addr_branch = '0; i_addr_jump = '0; i_addr_register = '0;
        i_halt = 0; i_load_valid = 0; i_load_data = '0;
    endtask

    // Drive one row, push its expectation, then pop and compare after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge i_clock);
        i_enable = v.en; i_pc_write = v.pcw; i_IF_ID_write = v.ifw;
        i_branch_or_jump = v.boj; i_pc_src = v.src; i_addr_branch = v.ab;
        i_addr_jump = v.aj; i_addr_register = v.ar; i_halt = v.halt; i_load_valid = 0;
        e.instr = v.e_instr; e.pc = v.e_pc; e.fpc = v.e_fpc; e.halted = v.e_halted;
        exp_q.push_back(e);
        @(posedge i_clock);
        #1;
        got = exp_q.pop_front();
        check({tag, " instr"},  o_instruction, got.instr);
        check({tag, " o_pc"},   32'(o_pc),     32'(got.pc));
        check({tag, " fpc"},    32'(o_fetch_pc), 32'(got.fpc));
        check({tag, " halted"}, 32'(o_halted), 32'(got.halted));
    endtask

    task automatic load_word(input logic [NB_DATA-1:0] data);
        @(negedge i_clock);
        idle_inputs();
        i_load_valid = 1;
        i_load_data  = data;
        @(posedge i_clock);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge i_clock);
        idle_inputs();
        i_reset = 0;
        #2;
        i_reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        i_reset = 0;
        #3;
        check("reset instr",  o_instruction, 32'h0);
        check("reset o_pc",   32'(o_pc), 32'h0);
        check("reset fpc",    32'(o_fetch_pc), 32'h0);
        check("reset full",   32'(o_load_full), 32'h0);
        check("reset halted", 32'(o_halted), 32'h0);
        @(negedge i_clock);
        i_reset = 1;

        // Overfill: DEPTH real words then three extras that must be dropped.
        for (int i = 0; i < DEPTH + 3; i++) begin
            load_word(i < DEPTH ? 32'hA0 + 32'(i) : 32'hEE0 + 32'(i));
            if (i == DEPTH - 2) check("full before last", 32'(o_load_full), 32'h0);
            if (i == DEPTH - 1) check("full after last",  32'(o_load_full), 32'h1);
            if (i == DEPTH + 2) check("full after extra", 32'(o_load_full), 32'h1);
        end
        run_vec("mem0 intact", mk(1,1,1,0,2'b00, 0,0,0, 0, 32'hA0, 1, 1, 0));

        // Reload the first four words; the rest keep 0xA0+i.
        pulse_reset();
        check("reload ptr cleared full", 32'(o_load_full), 32'h0);
        load_word(32'h11);
        load_word(32'h22);
        load_word(32'h33);
        load_word(32'h44);
        check("partial load not full", 32'(o_load_full), 32'h0);

        seg_a.push_back(mk(1,1,1,0,2'b00, 0,0,0, 0, 32'h11, 1, 1, 0));
        seg_a.push_back(mk(1,1,1,0,2'b00, 0,0,0, 0, 32'h22, 2, 2, 0));
        seg_a.push_back(mk(1,1,1,0,2'b00, 0,0,0, 0, 32'h33, 3, 3, 0));
        seg_a.push_back(mk(1,1,1,0,2'b00, 0,0,0, 0, 32'h44, 4, 4, 0));
        foreach (seg_a[i]) run_vec($sformatf("seq%0d", i), seg_a[i]);

        // Asynchronous reset between edges mid-run.
        #2;
        i_reset = 0;
        #1;
        check("midrun rst instr",  o_instruction, 32'h0);
        check("midrun rst o_pc",   32'(o_pc), 32'h0);
        check("midrun rst fpc",    32'(o_fetch_pc), 32'h0);
        check("midrun rst halted", 32'(o_halted), 32'h0);
        @(negedge i_clock);
        idle_inputs();
        i_reset = 1;

        //                en pcw ifw boj src    ab aj ar halt instr   o_pc fpc halted
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'h11,  1,  1, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'h22,  2,  2, 0));
        seg_b.push_back(mk(1,1,1,1,2'b01,  9,12,13, 0, 32'h00,  3,  9, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'hA9, 10, 10, 0));
        seg_b.push_back(mk(1,1,1,1,2'b10,  6,15, 7, 0, 32'h00, 11, 15, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'hAF,  0,  0, 0));
        seg_b.push_back(mk(1,1,1,1,2'b11,  8, 9, 3, 0, 32'h00,  1,  3, 0));
        seg_b.push_back(mk(1,0,0,0,2'b00,  0, 0, 0, 0, 32'h00,  1,  3, 0));
        seg_b.push_back(mk(1,0,0,0,2'b00,  0, 0, 0, 0, 32'h00,  1,  3, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'h44,  4,  4, 0));
        seg_b.push_back(mk(0,1,1,0,2'b00,  0, 0, 0, 0, 32'h44,  4,  4, 0));
        seg_b.push_back(mk(1,0,1,1,2'b11,  2, 3, 7, 0, 32'h00,  5,  4, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'hA4,  5,  5, 0));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 1, 32'hA5,  6,  5, 1));
        seg_b.push_back(mk(1,1,1,0,2'b00,  0, 0, 0, 0, 32'h00,  6,  5, 1));
        seg_b.push_back(mk(1,1,1,1,2'b01,  2, 3, 4, 0, 32'h00,  6,  5, 1));
        seg_b.push_back(mk(0,1,1,0,2'b00,  0, 0, 0, 0, 32'h00,  6,  5, 1));
        foreach (seg_b[i]) run_vec($sformatf("run%0d", i), seg_b[i]);

        pulse_reset();
        #1;
        check("halt cleared by reset", 32'(o_halted), 32'h0);
        check("pc cleared by reset",   32'(o_fetch_pc), 32'h0);
        run_vec("restart", mk(1,1,1,0,2'b00, 0,0,0, 0, 32'h11, 1, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
